// File: rtl/uart_tx_seq.sv
`timescale 1ns/1ps
// uart_tx_seq: snapshots six display bytes on a start request and hands them,
// one per frame slot, to a UART transmitter over a start/busy handshake.
// Slot n carries HEX(5-n), so slot 0 is HEX5 and slot 5 is HEX0.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     request one 6-byte frame (sampled only when idle)
//   HEX0..5   display bytes, captured when start is accepted
//   txbusy    transmitter is shifting a byte out
//   txdata    byte offered to the transmitter
//   txstart   transmit request, held until txbusy is seen high
//   addrwout  slot index of the byte in flight (0..5)
//   busy      frame in progress
//   done      one-cycle pulse after slot 5 completes
module uart_tx_seq #(
    parameter int unsigned IFG = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] HEX0,
    input  logic [7:0] HEX1,
    input  logic [7:0] HEX2,
    input  logic [7:0] HEX3,
    input  logic [7:0] HEX4,
    input  logic [7:0] HEX5,
    input  logic       txbusy,
    output logic [7:0] txdata,
    output logic       txstart,
    output logic [2:0] addrwout,
    output logic       busy,
    output logic       done
);

    localparam int unsigned GW      = (IFG > 0) ? $clog2(IFG + 1) : 1;
    localparam int unsigned NSLOT   = 6;
    localparam logic [2:0]  LAST    = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAITEND,
        GAP
    } state_t;

    state_t         state;
    logic [GW-1:0]  gap_cnt;
    logic [7:0]     shadow [NSLOT];

    logic           expire_c;
    logic [2:0]     next_slot_c;

    // Inter-frame gap over: either the counter ran out, or there is no gap and
    // the transmitter just went idle.
    assign expire_c    = ((state == WAITEND) && !txbusy && (IFG == 0)) ||
                         ((state == GAP) && (gap_cnt == '0));
    assign next_slot_c = addrwout + 3'd1;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            txdata   <= 8'hFF;
            txstart  <= 1'b0;
            addrwout <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                shadow[i] <= 8'hFF;
            end
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        shadow[0] <= HEX5;
                        shadow[1] <= HEX4;
                        shadow[2] <= HEX3;
                        shadow[3] <= HEX2;
                        shadow[4] <= HEX1;
                        shadow[5] <= HEX0;
                        addrwout  <= 3'd0;
                        txdata    <= HEX5;
                        txstart   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    // A txbusy already high here is taken as the acknowledge.
                    if (txbusy) begin
                        txstart <= 1'b0;
                        state   <= WAITEND;
                    end
                end

                WAITEND: begin
                    if (!txbusy && (IFG > 0)) begin
                        gap_cnt <= GW'(IFG - 1);
                        state   <= GAP;
                    end
                end

                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end

                default: state <= IDLE;
            endcase

            // Advance to the next slot or close the frame.
            if (expire_c) begin
                if (addrwout < LAST) begin
                    addrwout <= next_slot_c;
                    txdata   <= shadow[next_slot_c];
                    txstart  <= 1'b1;
                    state    <= SEND;
                end else begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    txstart <= 1'b0;
                    state   <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_seq.sv
`timescale 1ns/1ps
// Bench for uart_tx_seq: two instances (IFG=2 and IFG=0) driven by simple
// transmitter models; expected bytes are queued at stimulus time and a
// monitor pops them as each byte is offered.
module tb_uart_tx_seq;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (IFG=2)
    logic       rst0, start0, txbusy0;
    logic [7:0] hex_a [6];
    logic [7:0] txdata0;
    logic       txstart0, busy0, done0;
    logic [2:0] addrwout0;

    // Instance B (IFG=0)
    logic       rst1, start1, txbusy1;
    logic [7:0] hex_b [6];
    logic [7:0] txdata1;
    logic       txstart1, busy1, done1;
    logic [2:0] addrwout1;

    uart_tx_seq #(.IFG(2)) dut_a (
        .clk(clk), .rst(rst0), .start(start0),
        .HEX0(hex_a[0]), .HEX1(hex_a[1]), .HEX2(hex_a[2]),
        .HEX3(hex_a[3]), .HEX4(hex_a[4]), .HEX5(hex_a[5]),
        .txbusy(txbusy0), .txdata(txdata0), .txstart(txstart0),
        .addrwout(addrwout0), .busy(busy0), .done(done0)
    );

    uart_tx_seq #(.IFG(0)) dut_b (
        .clk(clk), .rst(rst1), .start(start1),
        .HEX0(hex_b[0]), .HEX1(hex_b[1]), .HEX2(hex_b[2]),
        .HEX3(hex_b[3]), .HEX4(hex_b[4]), .HEX5(hex_b[5]),
        .txbusy(txbusy1), .txdata(txdata1), .txstart(txstart1),
        .addrwout(addrwout1), .busy(busy1), .done(done1)
    );

    typedef struct packed {
        logic [2:0] slot;
        logic [7:0] data;
        logic [3:0] hi;     // cycles txstart must stay high
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int ack_dly0 = 1;
    int busy_len = 10;
    bit hold_b   = 1'b0;

    bit   in_byte   [2];
    int   hi_cnt    [2];
    exp_t cur       [2];
    bit   prev_busy [2];
    bit   prev_done [2];
    int   fall_cyc  [2];
    int   done_pend [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic chk_reset(input string tag, input logic [7:0] td, input logic ts,
                             input logic [2:0] ad, input logic bz, input logic dn);
        chk({tag, "_txdata"},   32'(td), 32'hFF);
        chk({tag, "_txstart"},  32'(ts), 32'd0);
        chk({tag, "_addrwout"}, 32'(ad), 32'd0);
        chk({tag, "_busy"},     32'(bz), 32'd0);
        chk({tag, "_done"},     32'(dn), 32'd0);
    endtask

    // Queue one frame; v = {HEX5,HEX4,HEX3,HEX2,HEX1,HEX0}, slot n = HEX(5-n).
    task automatic push_frame(input int d, input logic [47:0] v, input int hi);
        exp_t e;
        for (int n = 0; n < 6; n++) begin
            e.slot = 3'(n);
            e.data = v[47 - 8*n -: 8];
            e.hi   = 4'(hi);
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
        done_pend[d]++;
    endtask

    task automatic mon(input int d, input logic ts, input logic tbz, input logic [7:0] td,
                       input logic [2:0] ad, input logic bz, input logic dn, input logic rs);
        int qsz;
        if (rs) begin
            in_byte[d]   = 1'b0;
            prev_busy[d] = 1'b0;
            prev_done[d] = 1'b0;
            return;
        end
        if (prev_busy[d] && !tbz) fall_cyc[d] = cyc;
        if (ts) begin
            if (!in_byte[d]) begin
                in_byte[d] = 1'b1;
                hi_cnt[d]  = 1;
                qsz = (d == 0) ? qa.size() : qb.size();
                if (qsz == 0) begin
                    fail_now($sformatf("unexpected_txstart dut%0d slot=%0d data=%0h", d, ad, td));
                    cur[d] = '0;
                end else begin
                    if (d == 0) cur[d] = qa.pop_front();
                    else        cur[d] = qb.pop_front();
                    chk($sformatf("slot dut%0d", d), 32'(ad), 32'(cur[d].slot));
                    chk($sformatf("txdata dut%0d slot%0d", d, cur[d].slot), 32'(td), 32'(cur[d].data));
                    if (cur[d].slot != 3'd0)
                        chk($sformatf("gap dut%0d slot%0d", d, cur[d].slot),
                            32'(cyc - fall_cyc[d]), (d == 0) ? 32'd2 : 32'd0);
                end
            end else begin
                hi_cnt[d]++;
                chk($sformatf("hold_data dut%0d", d), 32'(td), 32'(cur[d].data));
                chk($sformatf("hold_slot dut%0d", d), 32'(ad), 32'(cur[d].slot));
            end
            chk($sformatf("busy_in_frame dut%0d", d), 32'(bz), 32'd1);
        end else if (in_byte[d]) begin
            in_byte[d] = 1'b0;
            chk($sformatf("txstart_len dut%0d slot%0d", d, cur[d].slot), 32'(hi_cnt[d]), 32'(cur[d].hi));
            chk($sformatf("ack_seen dut%0d", d), 32'(tbz), 32'd1);
        end
        if (dn) begin
            chk($sformatf("done_single dut%0d", d), 32'(prev_done[d]), 32'd0);
            chk($sformatf("done_expected dut%0d", d), 32'(done_pend[d] > 0), 32'd1);
            chk($sformatf("done_busy dut%0d", d), 32'(bz), 32'd0);
            chk($sformatf("done_slot dut%0d", d), 32'(ad), 32'd5);
            if (done_pend[d] > 0) done_pend[d]--;
        end
        prev_done[d] = dn;
        prev_busy[d] = tbz;
    endtask

    // Monitor: sample just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mon(0, txstart0, txbusy0, txdata0, addrwout0, busy0, done0, rst0);
            mon(1, txstart1, txbusy1, txdata1, addrwout1, busy1, done1, rst1);
        end
    end

    // Transmitter model A: acknowledge ack_dly0 cycles after txstart, then busy.
    initial begin
        txbusy0 = 1'b0;
        forever begin
            @(negedge clk);
            if (txstart0 && !rst0) begin
                repeat (ack_dly0 - 1) @(negedge clk);
                txbusy0 = 1'b1;
                repeat (busy_len) @(negedge clk);
                txbusy0 = 1'b0;
            end
        end
    end

    // Transmitter model B: immediate acknowledge; hold_b keeps txbusy high while idle.
    initial begin
        txbusy1 = 1'b0;
        forever begin
            @(negedge clk);
            if (txstart1 && !rst1) begin
                txbusy1 = 1'b1;
                repeat (busy_len) @(negedge clk);
                txbusy1 = 1'b0;
            end else begin
                txbusy1 = hold_b;
            end
        end
    end

    task automatic set_hex_a(input logic [47:0] v);
        for (int k = 0; k < 6; k++) hex_a[k] = v[8*k +: 8];
    endtask

    task automatic set_hex_b(input logic [47:0] v);
        for (int k = 0; k < 6; k++) hex_b[k] = v[8*k +: 8];
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done(input int d, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            if ((d == 0) ? done0 : done1) return;
        end
        fail_now($sformatf("timeout_done dut%0d", d));
    endtask

    task automatic wait_slot_a(input logic [2:0] s, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            #1;
            if (addrwout0 == s) return;
        end
        fail_now($sformatf("timeout_slot%0d", s));
    endtask

    task automatic wait_txbusy_a(input logic lvl, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            #1;
            if (txbusy0 == lvl) return;
        end
        fail_now($sformatf("timeout_txbusy%0d", lvl));
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        set_hex_a(48'h0);
        set_hex_b(48'h0);
        for (int d = 0; d < 2; d++) begin
            in_byte[d] = 0; hi_cnt[d] = 0; cur[d] = '0; prev_busy[d] = 0;
            prev_done[d] = 0; fall_cyc[d] = 0; done_pend[d] = 0;
        end

        // Reset values before any clock edge.
        #1;
        chk_reset("rst_init_a", txdata0, txstart0, addrwout0, busy0, done0);
        chk_reset("rst_init_b", txdata1, txstart1, addrwout1, busy1, done1);
        repeat (2) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 1: full frame with mid-frame HEX change and ignored start.
        set_hex_a(48'h112233445566);
        push_frame(0, 48'h112233445566, 1);
        pulse_start_a();
        wait_slot_a(3'd2, 500);
        hex_a[0] = 8'hAA;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 1000);
        repeat (4) @(negedge clk);
        chk("idle_busy_a", 32'(busy0), 32'd0);
        chk("idle_txstart_a", 32'(txstart0), 32'd0);
        chk("idle_hold_txdata_a", 32'(txdata0), 32'h66);

        // Frame 2: slow acknowledge (7 cycles).
        ack_dly0 = 7;
        set_hex_a(48'hA1B2C3D4E5F6);
        push_frame(0, 48'hA1B2C3D4E5F6, 7);
        pulse_start_a();
        wait_done(0, 2000);
        ack_dly0 = 1;
        repeat (3) @(negedge clk);

        // Frame 3: abort with reset during the slot 3 gap, then a fresh frame.
        set_hex_a(48'h010203040506);
        push_frame(0, 48'h010203040506, 1);
        pulse_start_a();
        wait_slot_a(3'd3, 500);
        wait_txbusy_a(1'b1, 50);
        wait_txbusy_a(1'b0, 50);
        @(posedge clk);
        #2;
        rst0 = 1'b1;
        #1;
        chk_reset("rst_abort_a", txdata0, txstart0, addrwout0, busy0, done0);
        qa.delete();
        done_pend[0] = 0;
        @(negedge clk);
        rst0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_idle_busy_a", 32'(busy0), 32'd0);
        chk("abort_idle_done_a", 32'(done0), 32'd0);
        set_hex_a(48'hF0E1D2C3B4A5);
        push_frame(0, 48'hF0E1D2C3B4A5, 1);
        pulse_start_a();
        wait_done(0, 1000);

        // Instance B: IFG=0, txbusy already high on first SEND cycle, then back-to-back frame.
        hold_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        set_hex_b(48'h5A6B7C8D9EAF);
        push_frame(1, 48'h5A6B7C8D9EAF, 1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        hold_b = 1'b0;
        wait_done(1, 1000);
        // Still in the done cycle: start here is accepted as a back-to-back frame.
        set_hex_b(48'h123456789ABC);
        push_frame(1, 48'h123456789ABC, 1);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        chk("b2b_busy_b", 32'(busy1), 32'd1);
        chk("b2b_slot0_data_b", 32'(txdata1), 32'h12);
        wait_done(1, 1000);

        repeat (5) @(negedge clk);
        chk("end_queue_a", 32'(qa.size()), 32'd0);
        chk("end_queue_b", 32'(qb.size()), 32'd0);
        chk("end_done_pend_a", 32'(done_pend[0]), 32'd0);
        chk("end_done_pend_b", 32'(done_pend[1]), 32'd0);
        chk("end_busy_a", 32'(busy0), 32'd0);
        chk("end_busy_b", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
